adam_syscfg_mctl: RTL
=====================

// Module: adam_syscfg_mctl
// PURPOSE
// Parametrised multi-target system-config controller; next generation of the per-target syscfg slaves.
// One APB slave drives reset, pause, boot address and masked IRQ for NO_TGTS targets.
// Adds a per-target STOP/START/SUSPEND sequencer, pause-ack timeout, ordered post-reset bootstrap and a global pause.
// PARAMETERS
// NO_TGTS         8    number of controlled targets (1..64)
// DATA_WIDTH      32   APB data width; ADDR_WIDTH == DATA_WIDTH required
// ADDR_WIDTH      32   APB address / boot address width
// IRQ_WIDTH       32   system IRQ vector width (<= DATA_WIDTH)
// BOOTSTRAP_MASK  '0   [NO_TGTS] bit i=1: target i auto-started after reset
// BOOT_ADDR_RST   '0   reset value of every BOOT_ADDR register
// TIMEOUT_CYCLES  1024 max cycles waiting for a target pause ack change
// PORTS
// seq.clk        in   1              single clock, all logic rising edge
// seq.rst        in   1              reset, synchronous, active-high
// pause_req      in   1              global pause request
// pause_ack      out  1              global pause acknowledge
// paddr/psel/penable/pwrite/pwdata/pstrb  in  APB4 slave request (ADDR/1/1/1/DATA/DATA/8)
// prdata/pready/pslverr                   out APB4 slave response (DATA/1/1)
// irq_vec        in   IRQ_WIDTH      system interrupt sources
// tgt_rst        out  NO_TGTS        per-target reset (1 = held)
// tgt_pause_req  out  NO_TGTS        per-target pause request
// tgt_pause_ack  in   NO_TGTS        per-target pause acknowledge
// tgt_boot_addr  out  NO_TGTS*ADDR   per-target boot address
// tgt_irq        out  NO_TGTS        per-target IRQ = |(irq_vec & IRQ_MASK[i]), registered
// BEHAVIOUR
// Clocking: one clock; reset is synchronous and active-high.
// Reset values: tgt_rst='1, tgt_pause_req='1, tgt_boot_addr=BOOT_ADDR_RST, IRQ_MASK=0, tgt_irq=0, pause_ack=0, flags=0.
// APB: zero wait (pready=1); prdata/pslverr combinational in access phase.
// - tgt = paddr[..:4], reg = paddr[3:2]; tgt >= NO_TGTS -> pslverr=1, prdata=0, no effect.
// - 0x0 STATUS RO: b0 rst, b1 paused (req&ack), b2 busy, b3 timeout (sticky); writes ignored, no error.
// - 0x4 ACTION WO (pwdata[1:0], needs pstrb[0]): 1 STOP, 2 START, 3 SUSPEND, 0 no-op; reads 0.
// - 0x8 BOOT_ADDR RW, 0xC IRQ_MASK RW [IRQ_WIDTH-1:0]; both honour pstrb.
// - ACTION while target busy, bootstrap active or pause_req=1 -> pslverr=1, ignored.
// - ACTION write clears the target's timeout flag.
// - Illegal ACTION for state (e.g. START in RUN): no-op, no error.
// Per-target FSM, outputs registered, transitions one cycle after the accepted write:
// - STOPPED  rst=1 req=1 : START -> RELEASE
// - RELEASE  rst=0 req=1 : one cycle -> RESUMING
// - RESUMING rst=0 req=0 : ack==0 -> RUN
// - RUN      rst=0 req=0 : STOP/SUSPEND -> PAUSING (STOP remembered)
// - PAUSING  rst=0 req=1 : ack==1 -> STOPPED if STOP, else PAUSED
// - PAUSED   rst=0 req=1 : START -> RESUMING; STOP -> STOPPED
// - busy = PAUSING|RELEASE|RESUMING.
// Timeout: counter clears on state entry and counts in PAUSING/RESUMING.
// - Reaching TIMEOUT_CYCLES sets the timeout flag and forces RUN (req=0); ack arriving on the same cycle wins.
// Bootstrap: after reset release, masked targets START in ascending index order.
// - Next target starts the cycle after the previous reaches RUN or times out; unmasked targets stay STOPPED.
// Global pause: pause_req blocks new ACTIONs and holds the bootstrap pointer.
// - pause_ack=1 the cycle after pause_req=1 and no target busy.
// - pause_ack drops the cycle after pause_req falls.
// Reset mid-operation: every FSM returns to STOPPED, bootstrap restarts from index 0.
// TESTING
// T1 BOOTSTRAP_MASK=3'b101, acks mirror req +2 cycles: tgt0 reaches RUN, then tgt2; tgt1 rst stays 1.
// T2 tgt1 RUN, write 0x14=1, ack after 3 cycles: req=1 next cycle, rst=1 cycle after ack, STATUS 0x10=0x3.
// T3 tgt3 RUN, ack stuck 0, write 0x34=3: after TIMEOUT_CYCLES req=0, STATUS bit3=1; next ACTION clears it.
// T4 IRQ_MASK tgt0=0x4, irq_vec=0x4 -> tgt_irq[0]=1 next cycle; irq_vec=0x2 -> 0.
// T5 paddr=NO_TGTS*16 -> pslverr=1, prdata=0; ACTION to a busy target -> pslverr=1, state unchanged.
// T6 pause_req during tgt2 PAUSING -> pause_ack only after ack completes; ACTION while paused -> pslverr=1.

Source files
------------

// File: rtl/adam_syscfg_mctl.sv
// adam_syscfg_mctl: APB-controlled reset/pause/boot/IRQ sequencer for NO_TGTS targets
// with per-target STOP/START/SUSPEND FSM, ack timeout, ordered bootstrap and global pause.
module adam_syscfg_mctl #(
   parameter int                    NO_TGTS        = 8,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    IRQ_WIDTH      = 32,
   parameter logic [NO_TGTS-1:0]    BOOTSTRAP_MASK = '0,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR_RST  = '0,
   parameter int                    TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pause_req,
   output logic                          pause_ack,
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [DATA_WIDTH-1:0]         pwdata,
   input  logic [DATA_WIDTH/8-1:0]       pstrb,
   output logic [DATA_WIDTH-1:0]         prdata,
   output logic                          pready,
   output logic                          pslverr,
   input  logic [IRQ_WIDTH-1:0]          irq_vec,
   output logic [NO_TGTS-1:0]            tgt_rst,
   output logic [NO_TGTS-1:0]            tgt_pause_req,
   input  logic [NO_TGTS-1:0]            tgt_pause_ack,
   output logic [NO_TGTS*ADDR_WIDTH-1:0] tgt_boot_addr,
   output logic [NO_TGTS-1:0]            tgt_irq
);
   localparam int TW = NO_TGTS > 1 ? $clog2(NO_TGTS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [2:0] {STOPPED, RELEASE, RESUMING, RUN, PAUSING, PAUSED} state_t;
   logic                         access, valid, reg_wr, act_wr, act_err, act_go;
   logic [TW-1:0]                t, boot_idx;
   logic [1:0]                   r;
   logic [DATA_WIDTH-1:0]        wmask;
   logic [NO_TGTS-1:0]           busy, run_v, tmo;
   logic [NO_TGTS*IRQ_WIDTH-1:0] masks;
   logic                         boot_done, boot_wait, boot_go, boot_start;
   logic                         unused_ok;
   assign unused_ok = ^paddr[1:0];
   for (genvar s = 0; s < DATA_WIDTH/8; s++) begin : g_strb
      assign wmask[s*8 +: 8] = {8{pstrb[s]}};
   end
   assign access  = psel & penable;
   assign t       = paddr[TW+3:4];
   assign r       = paddr[3:2];
   assign valid   = paddr[ADDR_WIDTH-1:4] < (ADDR_WIDTH-4)'(NO_TGTS);
   assign reg_wr  = access & pwrite & valid;
   assign act_wr  = reg_wr & (r == 2'd1);
   assign act_err = act_wr & (busy[t] | ~boot_done | pause_req);
   assign act_go  = act_wr & ~act_err & pstrb[0];
   assign pready  = 1'b1;
   assign pslverr = access & (~valid | act_err);
   assign prdata  = ~(access & valid) ? '0 :
                    r == 2'd0 ? DATA_WIDTH'({tmo[t], busy[t], tgt_pause_req[t] & tgt_pause_ack[t], tgt_rst[t]}) :
                    r == 2'd2 ? tgt_boot_addr[t*ADDR_WIDTH +: ADDR_WIDTH] :
                    r == 2'd3 ? DATA_WIDTH'(masks[t*IRQ_WIDTH +: IRQ_WIDTH]) : '0;
   // Bootstrap walks targets in order; a started target must reach RUN before moving on.
   assign boot_go    = ~boot_done & ~pause_req;
   assign boot_start = boot_go & ~boot_wait & BOOTSTRAP_MASK[boot_idx];
   always_ff @(posedge clk) begin
      if (rst) begin
         boot_idx  <= '0;
         boot_done <= 1'b0;
         boot_wait <= 1'b0;
         pause_ack <= 1'b0;
      end else begin
         pause_ack <= pause_req & ~|busy;
         if (boot_go) begin
            if (boot_wait ? run_v[boot_idx] : ~BOOTSTRAP_MASK[boot_idx]) begin
               boot_wait <= 1'b0;
               boot_done <= boot_idx == TW'(NO_TGTS - 1);
               boot_idx  <= boot_idx + 1'b1;
            end else begin
               boot_wait <= 1'b1;
            end
         end
      end
   end
   for (genvar g = 0; g < NO_TGTS; g++) begin : g_tgt
      state_t                st, nx;
      logic                  sel, wait_st, ack_done, tmo_ev, stop_q, tmo_q, rst_q, req_q, irq_q;
      logic [1:0]            cmd;
      logic [CW-1:0]         cnt;
      logic [ADDR_WIDTH-1:0] boot;
      logic [IRQ_WIDTH-1:0]  mask;
      assign sel      = t == TW'(g);
      assign cmd      = act_go & sel ? pwdata[1:0] : boot_start & (boot_idx == TW'(g)) ? 2'd2 : 2'd0;
      assign wait_st  = st == PAUSING || st == RESUMING;
      assign ack_done = st == PAUSING ? tgt_pause_ack[g] : ~tgt_pause_ack[g];
      assign tmo_ev   = wait_st & ~ack_done & (cnt == CW'(TIMEOUT_CYCLES - 1));
      always_comb begin
         nx = st;
         case (st)
            STOPPED:  nx = cmd == 2'd2 ? RELEASE : STOPPED;
            RELEASE:  nx = RESUMING;
            RESUMING: nx = ack_done | tmo_ev ? RUN : RESUMING;
            RUN:      nx = cmd[0] ? PAUSING : RUN;
            PAUSING:  nx = ack_done ? (stop_q ? STOPPED : PAUSED) : tmo_ev ? RUN : PAUSING;
            PAUSED:   nx = cmd == 2'd2 ? RESUMING : cmd == 2'd1 ? STOPPED : PAUSED;
            default:  nx = STOPPED;
         endcase
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            st     <= STOPPED;
            stop_q <= 1'b0;
            tmo_q  <= 1'b0;
            rst_q  <= 1'b1;
            req_q  <= 1'b1;
            cnt    <= '0;
            boot   <= BOOT_ADDR_RST;
            mask   <= '0;
            irq_q  <= 1'b0;
         end else begin
            st    <= nx;
            rst_q <= nx == STOPPED;
            req_q <= nx == STOPPED || nx == RELEASE || nx == PAUSING || nx == PAUSED;
            cnt   <= nx != st ? '0 : wait_st ? cnt + 1'b1 : cnt;
            tmo_q <= tmo_ev | (tmo_q & ~(act_go & sel));
            irq_q <= |(irq_vec & mask);
            if (st == RUN && cmd[0]) stop_q <= ~cmd[1];
            if (reg_wr & sel & (r == 2'd2)) boot <= (boot & ~wmask) | (pwdata & wmask);
            if (reg_wr & sel & (r == 2'd3)) mask <= (mask & ~wmask[IRQ_WIDTH-1:0]) | (pwdata[IRQ_WIDTH-1:0] & wmask[IRQ_WIDTH-1:0]);
         end
      end
      assign tgt_rst[g]                             = rst_q;
      assign tgt_pause_req[g]                       = req_q;
      assign tgt_irq[g]                             = irq_q;
      assign busy[g]                                = st == PAUSING || st == RELEASE || st == RESUMING;
      assign run_v[g]                               = st == RUN;
      assign tmo[g]                                 = tmo_q;
      assign tgt_boot_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = boot;
      assign masks[g*IRQ_WIDTH +: IRQ_WIDTH]        = mask;
   end
endmodule
